servo_pwm_multi: RTL

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pkg.sv | 37 +++
 rtl/servo_slew_ch.sv | 53 +++++
 rtl/servo_pwm_multi.sv | 98 +++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// servo_pkg -- shared constants and helpers for the multi-channel servo PWM block.
//
// Holds the parameter defaults (frame length, pulse limits, neutral width,
// slew step) and the two pure helpers every channel uses:
//   clamp_width : force a requested width into [lo, hi]
//   slew_step   : move one step from cur toward tgt, never past tgt
// Helpers work on 32-bit values; callers truncate back to the counter width.
package servo_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_CTR_W      = 20;
    localparam int DEF_PERIOD_CYC = 1000000;  // 20 ms at 50 MHz
    localparam int DEF_MIN_CYC    = 37500;
    localparam int DEF_MAX_CYC    = 112500;
    localparam int DEF_CENTER_CYC = 70000;
    localparam int DEF_SLEW_CYC   = 0;        // 0 = jump straight to target
    localparam int CH_IDX_W       = 4;        // width of the write channel index

    function automatic logic [31:0] clamp_width(input logic [31:0] w,
                                                input logic [31:0] lo,
                                                input logic [31:0] hi);
        if (w < lo) return lo;
        if (w > hi) return hi;
        return w;
    endfunction

    // Differences are taken only in the direction that is non-negative, so the
    // unsigned arithmetic can neither wrap nor step beyond the target.
    function automatic logic [31:0] slew_step(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
        if (step == 32'd0) return tgt;
        if (tgt > cur) return ((tgt - cur) > step) ? (cur + step) : tgt;
        return ((cur - tgt) > step) ? (cur - step) : tgt;
    endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// servo_slew_ch -- target / applied-width state for one servo channel.
//
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   wr_en      : write strobe already decoded for this channel
//   wr_width   : requested width, clamped here before it is stored
//   boundary   : high in the last cycle of a frame (counter == PERIOD-1)
//   cur        : width applied to the pulse generator this frame
//   at_target  : registered (cur == tgt)
//
// cur only moves at the frame boundary, so a write never disturbs the pulse
// already in progress. A write landing in the boundary cycle updates tgt on
// the same edge that cur steps, and that step still sees the old tgt.
module servo_slew_ch
    import servo_pkg::*;
#(
    parameter int CTR_W      = DEF_CTR_W,
    parameter int MIN_CYC    = DEF_MIN_CYC,
    parameter int MAX_CYC    = DEF_MAX_CYC,
    parameter int CENTER_CYC = DEF_CENTER_CYC,
    parameter int SLEW_CYC   = DEF_SLEW_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CTR_W-1:0] wr_width,
    input  logic             boundary,
    output logic [CTR_W-1:0] cur,
    output logic             at_target
);

    localparam logic [CTR_W-1:0] CENTER = CTR_W'(CENTER_CYC);

    logic [CTR_W-1:0] tgt;
    logic [CTR_W-1:0] clamped;
    logic [CTR_W-1:0] cur_next;

    assign clamped  = CTR_W'(clamp_width(32'(wr_width), MIN_CYC, MAX_CYC));
    assign cur_next = CTR_W'(slew_step(32'(cur), 32'(tgt), SLEW_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt       <= CENTER;
            cur       <= CENTER;
            at_target <= 1'b1;
        end else begin
            if (wr_en)    tgt <= clamped;
            if (boundary) cur <= cur_next;
            at_target <= (cur == tgt);
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi -- NUM_CH servo PWM outputs sharing one frame counter.
//
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   wr_en        : one-cycle write strobe
//   wr_ch        : channel index for the write (>= NUM_CH is rejected)
//   wr_width     : requested pulse width in clocks (clamped to MIN..MAX)
//   ch_en        : per-channel enable, latched only at frame boundaries
//   servo_out    : PWM outputs, high for cur[i] clocks from frame start
//   frame_start  : one-cycle pulse on the first cycle of each frame
//   at_target    : per channel, applied width has reached the target
//   wr_err       : one-cycle pulse the cycle after a rejected write
//
// Write interface: wr_en is a fire-and-forget strobe with no ready/back-pressure;
// every cycle with wr_en=1 is one write, accepted on that clock edge.
//
// All outputs are registered from the counter value before the edge, so pulse
// i is high for exactly cur[i] cycles starting with the frame_start cycle.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CTR_W      = DEF_CTR_W,
    parameter int PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int MIN_CYC    = DEF_MIN_CYC,
    parameter int MAX_CYC    = DEF_MAX_CYC,
    parameter int CENTER_CYC = DEF_CENTER_CYC,
    parameter int SLEW_CYC   = DEF_SLEW_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_IDX_W-1:0] wr_ch,
    input  logic [CTR_W-1:0]    wr_width,
    input  logic [NUM_CH-1:0]   ch_en,
    output logic [NUM_CH-1:0]   servo_out,
    output logic                frame_start,
    output logic [NUM_CH-1:0]   at_target,
    output logic                wr_err
);

    localparam logic [CTR_W-1:0]    LAST_CNT = CTR_W'(PERIOD_CYC - 1);
    localparam logic [CH_IDX_W:0]   NUM_CH_X = (CH_IDX_W + 1)'(NUM_CH);

    logic [CTR_W-1:0]  counter;
    logic              boundary;
    logic [NUM_CH-1:0] en_lat;
    logic [NUM_CH-1:0] ch_wr;
    logic [CTR_W-1:0]  cur [NUM_CH];

    assign boundary = (counter == LAST_CNT);

    // Free-running frame counter; never stalls.
    always_ff @(posedge clk) begin
        if (rst)           counter <= '0;
        else if (boundary) counter <= '0;
        else               counter <= counter + 1'b1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_wr[g] = wr_en && (wr_ch == CH_IDX_W'(g));

        servo_slew_ch #(
            .CTR_W      (CTR_W),
            .MIN_CYC    (MIN_CYC),
            .MAX_CYC    (MAX_CYC),
            .CENTER_CYC (CENTER_CYC),
            .SLEW_CYC   (SLEW_CYC)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (ch_wr[g]),
            .wr_width  (wr_width),
            .boundary  (boundary),
            .cur       (cur[g]),
            .at_target (at_target[g])
        );
    end

    // Enables are latched only at the boundary so toggling ch_en mid-frame
    // can neither cut a pulse short nor start a partial one.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_lat      <= '0;
            servo_out   <= '0;
            frame_start <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            if (boundary) en_lat <= ch_en;
            frame_start <= (counter == '0);
            wr_err      <= wr_en && ({1'b0, wr_ch} >= NUM_CH_X);
            for (int i = 0; i < NUM_CH; i++) begin
                servo_out[i] <= (counter < cur[i]) && en_lat[i];
            end
        end
    end

endmodule
